// File: rtl/hash_job_scheduler_pkg.sv
// Shared types and field widths for the hash job scheduler.
// Scheduler FSM states and the payload/target/nonce/hash widths of the hash core.
package hash_job_scheduler_pkg;

  localparam int PAYLOAD_W = 96;
  localparam int TARGET_W  = 8;
  localparam int NONCE_W   = 32;
  localparam int HASH_W    = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_GAP
  } state_e;

endpackage

// File: rtl/hash_job_scheduler_if.sv
// Requester, result and core-facing signals of the scheduler, bundled as one interface.
// The slave modport is the scheduler itself; the master modport is its environment.
interface hash_job_scheduler_if
  import hash_job_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);

  logic [NREQ-1:0]           req;
  logic [PAYLOAD_W*NREQ-1:0] req_payload;
  logic [TARGET_W*NREQ-1:0]  req_target;
  logic [NREQ-1:0]           ack;
  logic                      res_valid;
  logic [ID_W-1:0]           res_id;
  logic [NONCE_W-1:0]        res_nonce;
  logic [HASH_W-1:0]         res_hash;
  logic                      res_timeout;
  logic                      busy;
  logic [PAYLOAD_W-1:0]      core_payload;
  logic [TARGET_W-1:0]       core_target;
  logic                      core_active;
  logic                      core_terminado;
  logic [NONCE_W-1:0]        core_nonce;
  logic [HASH_W-1:0]         core_hash;

  modport slave (
    input  req, req_payload, req_target, core_terminado, core_nonce, core_hash,
    output ack, res_valid, res_id, res_nonce, res_hash, res_timeout, busy,
           core_payload, core_target, core_active
  );

  modport master (
    output req, req_payload, req_target, core_terminado, core_nonce, core_hash,
    input  ack, res_valid, res_id, res_nonce, res_hash, res_timeout, busy,
           core_payload, core_target, core_active
  );

endinterface

// File: rtl/hash_rr_pick.sv
// Round-robin picker: first set request bit at or above ptr, wrapping around.
// Purely combinational; the caller owns the pointer register.
module hash_rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    grant_valid = 1'b0;
    grant_id    = '0;
    // Scan farthest offset first so the closest requester to ptr is written last and wins.
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NREQ]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'((int'(ptr) + off) % NREQ);
      end
    end
  end

endmodule

// File: rtl/hash_job_scheduler.sv
// Shares one hash core among NREQ requesters: round-robin grant, job sequencing,
// timeout abort, tagged result return and a forced idle gap so the core re-inits.
module hash_job_scheduler
  import hash_job_scheduler_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ID_W       = 2,
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  hash_job_scheduler_if.slave bus
);

  // Counter serves both the RUN timeout and the GAP hold; GAP_CYCLES is assumed <= TIMEOUT.
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_e           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  cur_id;
  logic [CNT_W-1:0] cnt;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;

  hash_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req         (bus.req),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign bus.busy = (state != ST_IDLE);

  // NOTE: all state and registered outputs use non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      ptr              <= '0;
      cur_id           <= '0;
      cnt              <= '0;
      bus.ack          <= '0;
      bus.res_valid    <= 1'b0;
      bus.res_id       <= '0;
      bus.res_nonce    <= '0;
      bus.res_hash     <= '0;
      bus.res_timeout  <= 1'b0;
      bus.core_payload <= '0;
      bus.core_target  <= '0;
      bus.core_active  <= 1'b0;
    end else begin
      bus.ack       <= '0;
      bus.res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            bus.core_payload <= bus.req_payload[int'(grant_id) * PAYLOAD_W +: PAYLOAD_W];
            bus.core_target  <= bus.req_target[int'(grant_id) * TARGET_W +: TARGET_W];
            cur_id           <= grant_id;
            state            <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bus.core_active <= 1'b1;
          cnt             <= '0;
          state           <= ST_RUN;
        end
        ST_RUN: begin
          // terminado is tested first so a finish on the last allowed cycle is not a timeout.
          if (bus.core_terminado) begin
            bus.res_nonce   <= bus.core_nonce;
            bus.res_hash    <= bus.core_hash;
            bus.res_timeout <= 1'b0;
            bus.core_active <= 1'b0;
            bus.res_valid   <= 1'b1;
            bus.res_id      <= cur_id;
            bus.ack         <= NREQ'(1) << cur_id;
            state           <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.res_nonce   <= '0;
            bus.res_hash    <= '0;
            bus.res_timeout <= 1'b1;
            bus.core_active <= 1'b0;
            bus.res_valid   <= 1'b1;
            bus.res_id      <= cur_id;
            bus.ack         <= NREQ'(1) << cur_id;
            state           <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          ptr   <= (int'(cur_id) == NREQ - 1) ? '0 : cur_id + 1'b1;
          cnt   <= '0;
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_job_scheduler.sv
// Directed bench for hash_job_scheduler with a stub hash core that finishes after a
// programmable number of active cycles; expected values are hand-computed constants.
module tb_hash_job_scheduler;

  localparam int NREQ       = 4;
  localparam int ID_W       = 2;
  localparam int TIMEOUT    = 16;
  localparam int GAP_CYCLES = 2;

  logic clk;
  logic reset_n;

  hash_job_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  hash_job_scheduler #(
    .NREQ       (NREQ),
    .ID_W       (ID_W),
    .TIMEOUT    (TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub core: terminado rises once core_active has been seen high for stub_delay edges.
  logic        stub_en;
  int          stub_delay;
  logic [31:0] stub_nonce;
  logic [23:0] stub_hash;
  int          act_cnt;

  always @(posedge clk) begin
    if (!bus.core_active) act_cnt <= 0;
    else                  act_cnt <= act_cnt + 1;
  end

  assign bus.core_terminado = stub_en && bus.core_active && (act_cnt >= stub_delay);
  assign bus.core_nonce     = stub_nonce;
  assign bus.core_hash      = stub_hash;

  // Monitors: ack pulses, core_active high lengths, low gaps between jobs.
  logic [NREQ-1:0] ack_q[$];
  int              len_q[$];
  int              gap_q[$];
  int              hi_cnt;
  int              lo_cnt;
  logic            seen_job;

  initial begin
    hi_cnt   = 0;
    lo_cnt   = 0;
    seen_job = 1'b0;
    act_cnt  = 0;
  end

  always @(posedge clk) begin
    if (bus.ack != '0) ack_q.push_back(bus.ack);
    if (bus.core_active) begin
      if (lo_cnt != 0 && seen_job) gap_q.push_back(lo_cnt);
      lo_cnt   <= 0;
      seen_job <= 1'b1;
      hi_cnt   <= hi_cnt + 1;
    end else begin
      lo_cnt <= lo_cnt + 1;
      if (hi_cnt != 0) begin
        len_q.push_back(hi_cnt);
        hi_cnt <= 0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.res_valid !== 1'b1 && n < 200);
    check({tag, "_res_valid_seen"}, bus.res_valid, 1'b1);
  endtask

  task automatic wait_active(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.core_active !== 1'b1 && n < 200);
    check({tag, "_active_seen"}, bus.core_active, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  localparam logic [95:0] PAY0 = 96'h397d9f2f40ca9e6c6b1f3324;
  int exp_ids[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset_n         = 1'b0;
    bus.req         = '0;
    bus.req_payload = '0;
    bus.req_target  = '0;
    stub_en         = 1'b1;
    stub_delay      = 3;
    stub_nonce      = 32'hdeadbeef;
    stub_hash       = 24'h123456;

    // Reset state
    idle_cycles(3);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_core_active", bus.core_active, 1'b0);
    check("rst_ack", bus.ack, 4'b0000);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_nonce", bus.res_nonce, 32'h0);
    check("rst_core_payload", bus.core_payload, 96'h0);
    reset_n = 1'b1;
    idle_cycles(2);

    // 1: single job from requester 0
    bus.req_payload[95:0] = PAY0;
    bus.req_target[7:0]   = 8'h0a;
    bus.req               = 4'b0001;
    @(negedge clk);
    check("t1_load_active_low", bus.core_active, 1'b0);
    check("t1_load_busy", bus.busy, 1'b1);
    check("t1_core_payload", bus.core_payload, PAY0);
    check("t1_core_target", bus.core_target, 8'h0a);
    bus.req               = 4'b0000;
    bus.req_payload[95:0] = 96'h1;
    @(negedge clk);
    check("t1_active_rise", bus.core_active, 1'b1);
    wait_result("t1");
    check("t1_ack", bus.ack, 4'b0001);
    check("t1_res_id", bus.res_id, 2'd0);
    check("t1_res_nonce", bus.res_nonce, 32'hdeadbeef);
    check("t1_res_hash", bus.res_hash, 24'h123456);
    check("t1_res_timeout", bus.res_timeout, 1'b0);
    check("t1_payload_held", bus.core_payload, PAY0);
    @(negedge clk);
    check("t1_ack_pulse_end", bus.ack, 4'b0000);
    check("t1_res_valid_end", bus.res_valid, 1'b0);
    idle_cycles(5);
    check("t1_ack_count", ack_q.size(), 1);
    check("t1_active_len", len_q[0], 4);

    // 5: reset mid-RUN (ptr is 1 here, requester 1 is granted)
    stub_en = 1'b0;
    bus.req = 4'b0010;
    wait_active("t5");
    idle_cycles(3);
    #2 reset_n = 1'b0;
    #1;
    check("t5_active_async", bus.core_active, 1'b0);
    check("t5_busy_async", bus.busy, 1'b0);
    check("t5_res_nonce_async", bus.res_nonce, 32'h0);
    check("t5_res_hash_async", bus.res_hash, 24'h0);
    check("t5_core_payload_async", bus.core_payload, 96'h0);
    bus.req = 4'b0000;
    idle_cycles(3);
    check("t5_no_ack", ack_q.size(), 1);
    reset_n = 1'b1;
    idle_cycles(2);

    // 2: all requesters held, pointer back at 0 after reset
    ack_q.delete();
    len_q.delete();
    gap_q.delete();
    stub_en    = 1'b1;
    stub_delay = 5;
    stub_nonce = 32'hcafe0001;
    bus.req    = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_result("t2");
      if (i == 4) bus.req = 4'b0000;
      check("t2_ack_order", bus.ack, 4'b0001 << exp_ids[i]);
      check("t2_res_id", bus.res_id, exp_ids[i]);
    end
    idle_cycles(20);
    check("t2_ack_count", ack_q.size(), 5);
    check("t2_job_count", len_q.size(), 5);
    foreach (len_q[i]) check("t2_active_len", len_q[i], 6);
    foreach (gap_q[i]) check("t2_gap_min", (gap_q[i] >= GAP_CYCLES + 2), 1'b1);
    check("t2_idle_after", bus.busy, 1'b0);

    // 3: timeout (ptr is 1, requester 2 is the only one asking)
    len_q.delete();
    stub_en = 1'b0;
    bus.req = 4'b0100;
    wait_result("t3");
    bus.req = 4'b0000;
    check("t3_ack", bus.ack, 4'b0100);
    check("t3_res_id", bus.res_id, 2'd2);
    check("t3_res_timeout", bus.res_timeout, 1'b1);
    check("t3_res_nonce", bus.res_nonce, 32'h0);
    check("t3_res_hash", bus.res_hash, 24'h0);
    idle_cycles(3);
    check("t3_active_len", len_q[0], TIMEOUT);

    // 4: terminado on the last allowed cycle beats the timeout
    len_q.delete();
    stub_en    = 1'b1;
    stub_delay = TIMEOUT - 1;
    stub_nonce = 32'h0badf00d;
    stub_hash  = 24'habcdef;
    bus.req    = 4'b1000;
    wait_result("t4");
    bus.req = 4'b0000;
    check("t4_ack", bus.ack, 4'b1000);
    check("t4_res_timeout", bus.res_timeout, 1'b0);
    check("t4_res_nonce", bus.res_nonce, 32'h0badf00d);
    check("t4_res_hash", bus.res_hash, 24'habcdef);
    idle_cycles(3);
    check("t4_active_len", len_q[0], TIMEOUT);
    check("t4_timeout_held", bus.res_timeout, 1'b0);

    // 6: requester 1 withdraws during its RUN
    ack_q.delete();
    stub_delay = 8;
    bus.req    = 4'b0010;
    wait_active("t6");
    idle_cycles(2);
    bus.req = 4'b0000;
    wait_result("t6");
    check("t6_ack", bus.ack, 4'b0010);
    check("t6_res_id", bus.res_id, 2'd1);
    idle_cycles(20);
    check("t6_ack_once", ack_q.size(), 1);
    check("t6_not_regranted", bus.busy, 1'b0);
    check("t6_active_low", bus.core_active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
